// File: rtl/regfile_pkg.sv
// Shared register-file constants and types for the write-back arbiter.
// Priority encoding is chosen so the debug bit reads 1 when loads hold priority.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int ZERO_REG   = 31;

    typedef enum logic {
        PRI_ALU = 1'b0,
        PRI_MEM = 1'b1
    } wb_pri_e;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] mask;
        mask       = '0;
        mask[addr] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-requester round-robin arbiter for the register-file write port.
// gnt[0] = ALU, gnt[1] = MEM; at most one bit is ever set.
module wb_rr_arbiter
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_alu,
    input  logic       req_mem,
    output logic [1:0] gnt,
    output logic       pri_state
);

    wb_pri_e state_q;
    wb_pri_e state_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= PRI_MEM;
        end else begin
            state_q <= state_next;
        end
    end

    // A lone requester always wins; priority only breaks ties.
    always_comb begin
        gnt        = 2'b00;
        state_next = state_q;
        if (req_alu && req_mem) begin
            if (state_q == PRI_MEM) begin
                gnt[1] = 1'b1;
            end else begin
                gnt[0] = 1'b1;
            end
        end else if (req_mem) begin
            gnt[1] = 1'b1;
        end else if (req_alu) begin
            gnt[0] = 1'b1;
        end

        if (gnt[1]) begin
            state_next = PRI_ALU;
        end else if (gnt[0]) begin
            state_next = PRI_MEM;
        end
    end

    assign pri_state = state_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between ALU and load write-back, registers
// the winning write, and tracks pending destination writes in a busy scoreboard.
//
// Handshake: a source transfers on a cycle where valid && ready. ready is
// combinational from both valids and the arbiter priority; a stalled source
// keeps addr/data stable while valid && !ready.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int ZERO_REG = 31
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  alu_valid,
    input  logic [4:0]            alu_addr,
    input  logic [DATA_W-1:0]     alu_data,
    output logic                  alu_ready,
    input  logic                  mem_valid,
    input  logic [4:0]            mem_addr,
    input  logic [DATA_W-1:0]     mem_data,
    output logic                  mem_ready,
    input  logic                  claim_valid,
    input  logic [4:0]            claim_addr,
    output logic                  rf_wr_en,
    output logic [4:0]            rf_wr_addr,
    output logic [DATA_W-1:0]     rf_wr_data,
    output logic [NUM_REGS-1:0]   busy,
    output logic                  pri_state
);

    localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = REG_ADDR_W'(ZERO_REG);

    logic [1:0]            gnt;
    logic                  grant;
    logic [REG_ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0]     win_data;
    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   busy_next;

    wb_rr_arbiter u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_alu   (alu_valid),
        .req_mem   (mem_valid),
        .gnt       (gnt),
        .pri_state (pri_state)
    );

    assign alu_ready = gnt[0];
    assign mem_ready = gnt[1];
    assign grant     = gnt[0] | gnt[1];

    always_comb begin
        win_addr = alu_addr;
        win_data = alu_data;
        if (gnt[1]) begin
            win_addr = mem_addr;
            win_data = mem_data;
        end
    end

    // Zero-register writes still capture addr/data but never raise the enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_wr_en   <= 1'b0;
            rf_wr_addr <= '0;
            rf_wr_data <= '0;
        end else if (grant) begin
            rf_wr_en   <= (win_addr != ZERO_ADDR);
            rf_wr_addr <= win_addr;
            rf_wr_data <= win_data;
        end else begin
            rf_wr_en   <= 1'b0;
        end
    end

    // Clear before set so a same-cycle claim (the newer producer) wins.
    always_comb begin
        busy_next = busy_q;
        if (grant) begin
            busy_next = busy_next & ~reg_onehot(win_addr);
        end
        if (claim_valid && (claim_addr != ZERO_ADDR)) begin
            busy_next = busy_next | reg_onehot(claim_addr);
        end
        busy_next = busy_next & ~reg_onehot(ZERO_ADDR);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

    assign busy = busy_q;

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port between the two write-back sources of the 5-stage pipeline: ALU results (EX/WB) and load data (MEM/WB). It round-robins between requesters and registers the winning address/data/enable that drive the register file's 5-to-32 write-enable decoder. It also keeps a 32-entry busy scoreboard of pending destination writes for hazard detection in decode.

## Interface
- `DATA_W`, 64, write-data width
- `ZERO_REG`, 31, hard-wired zero register; writes to it are discarded
- `clk`  in  1  single clock, all state on rising edge
- `reset_n`  in  1  reset, asynchronous, active-low
- `alu_valid`  in  1  ALU write-back request
- `alu_addr`  in  5  ALU destination register
- `alu_data`  in  DATA_W  ALU result
- `alu_ready`  out  1  ALU request accepted this cycle
- `mem_valid`  in  1  load write-back request
- `mem_addr`  in  5  load destination register
- `mem_data`  in  DATA_W  load data
- `mem_ready`  out  1  load request accepted this cycle
- `claim_valid`  in  1  decode reserves a destination register
- `claim_addr`  in  5  register being reserved
- `rf_wr_en`  out  1  registered write enable to decoder
- `rf_wr_addr`  out  5  registered write address to decoder
- `rf_wr_data`  out  DATA_W  registered write data
- `busy`  out  32  scoreboard, bit i = write to register i pending

## Operation
- Handshake: transfer when `valid && ready`; `ready` is combinational from `valid` and arbiter state; requester holds addr/data stable while `valid && !ready`.
- At most one of `alu_ready`/`mem_ready` is high per cycle; a lone valid requester is always granted.
- Priority FSM, states `PRI_ALU`, `PRI_MEM`; reset state `PRI_MEM` (loads win first conflict).
  - Both valid: grant the prioritised source; next state points at the other.
  - One valid: grant it; next state points at the other source.
  - None valid: state holds.
- Output stage: on grant, capture addr/data next edge; `rf_wr_en` = 1 iff a grant occurred and addr != `ZERO_REG`. Otherwise `rf_wr_en` = 0, `rf_wr_addr`/`rf_wr_data` hold last values.
- Writes to `ZERO_REG` are accepted (ready asserted), consume the grant and rotate priority, but never drive `rf_wr_en`.
- Scoreboard, updated each edge:
  - Set bit `claim_addr` when `claim_valid` and `claim_addr != ZERO_REG`.
  - Clear bit `a` when a grant with address `a` occurs (same edge as output capture).
  - Same register claimed and cleared same cycle: set wins (newer producer).
  - Claim of a register already busy: stays set, no error.
  - `busy[ZERO_REG]` is constant 0.

## Timing
- Reset (asynchronous assert, synchronous-to-clock release): `rf_wr_en`=0, `rf_wr_addr`=0, `rf_wr_data`=0, `busy`=0, FSM=`PRI_MEM`; ready outputs follow valids combinationally.
- Reset mid-transfer: in-flight grant and pending busy bits are dropped; requester must re-present.
- Latency: grant in cycle N → `rf_wr_en` high in cycle N+1, exactly one cycle; busy bit clear visible in N+1.
- Throughput: one write per cycle; with both valid continuously, grants strictly alternate.
- Claim in cycle N → `busy` bit visible in N+1.

## Structure
- Package `regfile_pkg`: `REG_ADDR_W`=5, `NUM_REGS`=32, `ZERO_REG`=31, enum `wb_pri_e {PRI_ALU, PRI_MEM}`.
- Sub-module `wb_rr_arbiter`: two-request round-robin FSM, outputs one-hot grant; top level holds output register and scoreboard.

## Test plan
- Reset, then ALU alone: alu_addr=5, alu_data=0xA5 one cycle → next cycle rf_wr_en=1, rf_wr_addr=5, rf_wr_data=0xA5; then rf_wr_en=0.
- Conflict: both valid from reset, alu_addr=1, mem_addr=2, held 4 cycles → grants MEM, ALU, MEM, ALU; rf_wr_addr sequence 2,1,2,1.
- Zero register: alu_addr=31 valid → alu_ready=1, rf_wr_en stays 0, busy unchanged, priority rotates.
- Scoreboard: claim 7 in cycle 0 → busy[7]=1 at cycle 1; mem writes 7 in cycle 3 → busy[7]=0 at cycle 4; claim 7 and write 7 same cycle → busy[7] stays 1.
- Claim 31 → busy stays 0.
- Async reset asserted mid-stream with busy=0x0000_0090 and ALU stalled → busy=0, rf_wr_en=0 immediately, FSM=`PRI_MEM` after release.
